fsm_event_encoder: RTL

Upstream stage for the sleep/wake state machine: converts seven raw, level-type stimulus lines into the single 3-bit event code stream that drives the FSM's `input_signal`. Rising edges are captured, prioritised, queued in a small FIFO, and each event is presented for exactly one clock followed by a guaranteed idle gap (code 3'b000). This ensures the FSM never misses an event or sees one twice.

---
 rtl/fsm_event_pkg.sv | 33 +++
 rtl/event_fifo.sv | 50 +++++
 rtl/fsm_event_encoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fsm_event_pkg.sv
// Shared event codes and output-FSM states for the sleep/wake FSM
// and its upstream event encoder.
package fsm_event_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [2:0] {
    I_NONE      = 3'b000,
    I_GETTIRED  = 3'b001,
    I_LIEDOWN   = 3'b010,
    I_LIGHTSOFF = 3'b011,
    I_ALARM     = 3'b100,
    I_SUNRISE   = 3'b101,
    I_SHAKE     = 3'b110,
    I_COLDWATER = 3'b111
  } in_code_e;

  typedef enum logic [1:0] {
    O_IDLE = 2'b00,
    O_SHOW = 2'b01,
    O_GAP  = 2'b10
  } out_state_e;

  // Highest set index wins: wake codes (1xx) beat sleep codes.
  function automatic logic [2:0] hi_code(input logic [7:1] pend);
    logic [2:0] c;
    c = I_NONE;
    for (int i = 1; i <= 7; i++)
      if (pend[i]) c = 3'(i);
    return c;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Small synchronous FIFO holding 3-bit event codes.
// Pointers carry one extra wrap bit so full and empty differ.
module event_fifo
  import fsm_event_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CODE_W-1:0]        din,
  output logic [CODE_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CODE_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic              w_do_pop;
  logic              w_do_push;

  assign level     = r_wptr - r_rptr;
  assign full      = (level == (AW+1)'(DEPTH));
  assign empty     = (level == '0);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign dout      = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr[AW-1:0]] <= din;
        r_wptr                <= r_wptr + (AW+1)'(1);
      end
      if (w_do_pop)
        r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/fsm_event_encoder.sv
// Turns seven level request lines into a prioritised, queued stream
// of one-cycle event codes separated by idle gaps.
module fsm_event_encoder
  import fsm_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [6:0]             raw_req,
  input  logic                   hold,
  input  logic                   clr_overflow,
  output logic [2:0]             event_code,
  output logic                   event_valid,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [6:0]    r_req_q;
  logic [7:1]    r_pend;
  logic [7:1]    w_rise;
  logic [7:1]    w_clr;
  logic [7:0]    w_onehot;
  logic [2:0]    w_win;
  logic [2:0]    w_dout;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  logic          w_ovf_set;
  logic          r_ovf;

  out_state_e    r_state;
  out_state_e    w_state_nxt;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] w_gap_nxt;
  logic [2:0]    r_code;
  logic [2:0]    w_code_nxt;
  logic          r_valid;
  logic          w_valid_nxt;
  logic          w_ready;

  assign w_rise    = raw_req & ~r_req_q;
  assign w_win     = hi_code(r_pend);
  assign w_push    = (w_win != I_NONE) && (!w_full || w_pop);
  assign w_onehot  = 8'd1 << w_win;
  assign w_clr     = w_push ? w_onehot[7:1] : '0;
  // A re-rise on a bit leaving this cycle is a fresh event, not a loss.
  assign w_ovf_set = |(w_rise & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req_q <= '0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_req_q <= raw_req;
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (clr_overflow)
        r_ovf <= 1'b0;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_win),
    .dout    (w_dout),
    .level   (fifo_level),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= O_IDLE;
      r_gap   <= '0;
      r_code  <= I_NONE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // The last idle cycle of a presentation doubles as the pop slot.
  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_code_nxt  = I_NONE;
    w_valid_nxt = 1'b0;
    w_pop       = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      O_IDLE: w_ready = 1'b1;
      O_SHOW: begin
        if (GAP > 0) begin
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = O_GAP;
        end else begin
          w_ready = 1'b1;
        end
      end
      O_GAP: begin
        if (r_gap == '0)
          w_ready = 1'b1;
        else
          w_gap_nxt = r_gap - GW'(1);
      end
      default: w_state_nxt = O_IDLE;
    endcase
    if (w_ready) begin
      if (!w_empty && !hold) begin
        w_pop       = 1'b1;
        w_code_nxt  = w_dout;
        w_valid_nxt = 1'b1;
        w_state_nxt = O_SHOW;
      end else begin
        w_state_nxt = O_IDLE;
      end
    end
  end

  assign event_code  = r_code;
  assign event_valid = r_valid;
  assign overflow    = r_ovf;

endmodule
